mmio_led_ctrl: RTL and testbench

Memory-mapped LED output peripheral that snoops CPU data-bus stores and drives a parametrised LED bank. It replaces the hard-wired WriteData-to-LED mapping on the FPGA top level. It adds these features:
- address decode
- a latched data register
- a programmable prescaler
- four display modes: static, blink, rotate, count

It sits between cpu_top's data bus and the board LEDs.

---
 rtl/led_ctrl_pkg.sv | 14 +
 rtl/led_prescaler.sv | 21 ++
 rtl/mmio_led_ctrl.sv | 108 ++++++++++
 tb/tb_mmio_led_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared modes, register offsets and bit indices for mmio_led_ctrl.
package led_ctrl_pkg;
  typedef enum logic [1:0] {MODE_STATIC, MODE_BLINK, MODE_ROTATE, MODE_COUNT} led_mode_e;
  localparam logic [4:0] OFS_DATA   = 5'h00;
  localparam logic [4:0] OFS_CTRL   = 5'h04;
  localparam logic [4:0] OFS_PERIOD = 5'h08;
  localparam logic [4:0] OFS_STATUS = 5'h0C;
  localparam logic [4:0] OFS_DUTY   = 5'h10;
  localparam int CTRL_MODE_LSB = 0;
  localparam int CTRL_MODE_MSB = 1;
  localparam int CTRL_EN       = 2;
  localparam int STAT_PEND     = 0;
  localparam int STAT_EN       = 1;
endpackage

// File: rtl/led_prescaler.sv
// led_prescaler: reloadable down-counter emitting a one-cycle tick every PERIOD+1 enabled cycles.
module led_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             reload_i,
  input  logic [DIV_W-1:0] period_i,
  input  logic [DIV_W-1:0] load_i,
  output logic             tick_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick_o = en_i && !reload_i && cnt_q == '0;
    cnt_d  = reload_i ? load_i : !en_i ? cnt_q : tick_o ? period_i : cnt_q - DIV_W'(1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/mmio_led_ctrl.sv
// mmio_led_ctrl: bus-snooping LED peripheral with static/blink/rotate/count modes.
// Define LED_PWM_EN to add the DUTY register and PWM output gating.
module mmio_led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int          LED_W     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int          DIV_W     = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MemWrite,
  input  logic [31:0]      DataAdr,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
  output logic [LED_W-1:0] LEDS
);
  logic [LED_W-1:0] data_q, data_d, mode_out, leds_q, leds_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             phase_q, phase_d, pend_q, pend_d;
  logic             in_win, hit, wr_data, wr_ctrl, wr_period, rd_stat, en, tick;
  logic [4:0]       ofs;
  logic [7:0]       duty;
  led_mode_e        mode;
  logic             unused_wd;
  assign unused_wd = ^WriteData;
  assign in_win    = DataAdr[31:5] == BASE_ADDR[31:5] && DataAdr[1:0] == 2'b00;
  assign ofs       = DataAdr[4:0];
  assign hit       = MemWrite && in_win;
  assign wr_data   = hit && ofs == OFS_DATA;
  assign wr_ctrl   = hit && ofs == OFS_CTRL;
  assign wr_period = hit && ofs == OFS_PERIOD;
  assign rd_stat   = !MemWrite && in_win && ofs == OFS_STATUS;
  assign en        = ctrl_q[CTRL_EN];
  assign mode      = led_mode_e'(ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB]);
  led_prescaler #(.DIV_W(DIV_W)) u_pre (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en),
    .reload_i(wr_ctrl || wr_period),
    .period_i(period_q),
    .load_i  (period_d),
    .tick_o  (tick)
  );
  // A CPU store to DATA overrides any rotate/count step in the same cycle.
  always_comb begin
    data_d   = wr_data ? WriteData[LED_W-1:0] :
               !tick ? data_q :
               mode == MODE_ROTATE ? (data_q << 1) | (data_q >> (LED_W-1)) :
               mode == MODE_COUNT ? data_q + LED_W'(1) : data_q;
    ctrl_d   = wr_ctrl ? WriteData[2:0] : ctrl_q;
    period_d = wr_period ? WriteData[DIV_W-1:0] : period_q;
    phase_d  = wr_ctrl || (phase_q ^ (tick && mode == MODE_BLINK));
    pend_d   = tick || (pend_q && !rd_stat);
    mode_out = (en && mode == MODE_BLINK && !phase_q) ? '0 : data_q;
    rdata_d  = '0;
    if (in_win)
      case (ofs)
        OFS_DATA:   rdata_d = 32'(data_q);
        OFS_CTRL:   rdata_d = 32'(ctrl_q);
        OFS_PERIOD: rdata_d = 32'(period_q);
        OFS_STATUS: begin
          rdata_d[STAT_PEND] = pend_q;
          rdata_d[STAT_EN]   = en;
        end
        OFS_DUTY:   rdata_d = 32'(duty);
        default:    rdata_d = '0;
      endcase
  end
`ifdef LED_PWM_EN
  logic [7:0] duty_q, pwm_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      duty_q <= 8'hFF;
      pwm_q  <= '0;
    end else begin
      pwm_q <= pwm_q + 8'd1;
      if (hit && ofs == OFS_DUTY) duty_q <= WriteData[7:0];
    end
  assign duty   = duty_q;
  assign leds_d = mode_out & {LED_W{pwm_q < duty_q}};
`else
  assign duty   = 8'h00;
  assign leds_d = mode_out;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data_q   <= '0;
      ctrl_q   <= '0;
      period_q <= '0;
      phase_q  <= 1'b0;
      pend_q   <= 1'b0;
      rdata_q  <= '0;
      leds_q   <= '0;
    end else begin
      data_q   <= data_d;
      ctrl_q   <= ctrl_d;
      period_q <= period_d;
      phase_q  <= phase_d;
      pend_q   <= pend_d;
      rdata_q  <= rdata_d;
      leds_q   <= leds_d;
    end
  assign ReadData = rdata_q;
  assign LEDS     = leds_q;
endmodule

// File: tb/tb_mmio_led_ctrl.sv
// tb_mmio_led_ctrl: directed scoreboard bench for mmio_led_ctrl (default LED_W=16, BASE=0x100).
module tb_mmio_led_ctrl;
  localparam logic [31:0] BASE = 32'h0000_0100;
  typedef struct {string tag; logic [31:0] v;} exp_t;
  logic        clk = 1'b0, rst_n = 1'b0, MemWrite = 1'b0;
  logic [31:0] DataAdr = '0, WriteData = '0;
  logic [31:0] ReadData;
  logic [15:0] LEDS;
  int          errors = 0, checks = 0;
  exp_t        sb[$];
  always #5 clk = ~clk;
  mmio_led_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .MemWrite (MemWrite),
    .DataAdr  (DataAdr),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .LEDS     (LEDS)
  );
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; DataAdr = a; WriteData = d;
    step(1);
    MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
  endtask
  task automatic rd(input logic [31:0] a);
    DataAdr = a;
    step(1);
    DataAdr = '0;
  endtask
  task automatic push(input string t, input logic [31:0] v);
    sb.push_back('{t, v});
  endtask
  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h with nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
      end
    end
  endtask
  initial begin
    push("rst_leds", 32'h0); push("rst_rd", 32'h0);
    step(2);
    check({16'h0, LEDS}); check(ReadData);
    #2 rst_n = 1'b1;
    step(1);
    // Async reset in the middle of COUNT mode
    wr(BASE, 32'h5); wr(BASE + 8, 32'h0); wr(BASE + 4, 32'h7);
    DataAdr = BASE;
    push("cnt_mid_leds", 32'h7); push("cnt_mid_rd", 32'h7);
    step(3);
    check({16'h0, LEDS}); check(ReadData);
    push("async_leds", 32'h0); push("async_rd", 32'h0);
    #3 rst_n = 1'b0;
    #1 check({16'h0, LEDS}); check(ReadData);
    #2 rst_n = 1'b1; DataAdr = '0;
    push("post_rst_leds", 32'h0);
    step(2); check({16'h0, LEDS});
    push("post_rst_ctrl", 32'h0); rd(BASE + 4); check(ReadData);
    push("post_rst_data", 32'h0); rd(BASE);     check(ReadData);
    // Static write latency and decode rejection
    push("lat_edge", 32'h0);    wr(BASE, 32'h0000_ABCD); check({16'h0, LEDS});
    push("lat_next", 32'hABCD); step(1);                 check({16'h0, LEDS});
    push("misalign", 32'hABCD); wr(BASE + 1, 32'h1111); step(1); check({16'h0, LEDS});
    push("out_win",  32'hABCD); wr(32'h200, 32'h2222);  step(1); check({16'h0, LEDS});
    push("rd_data",  32'hABCD); rd(BASE); check(ReadData);
    // Rotate every 4 cycles
    wr(BASE, 32'h8001); wr(BASE + 8, 32'h3); wr(BASE + 4, 32'h6);
    push("rot0", 32'h8001); step(1); check({16'h0, LEDS});
    push("rot0_hold", 32'h8001); step(3); check({16'h0, LEDS});
    push("rot1", 32'h0003); step(1); check({16'h0, LEDS});
    push("rot2", 32'h0006); step(4); check({16'h0, LEDS});
    push("rot3", 32'h000C); step(4); check({16'h0, LEDS});
    // Count with wrap, and CPU write colliding with a tick
    wr(BASE + 4, 32'h0); wr(BASE, 32'hFFFF); wr(BASE + 8, 32'h0); wr(BASE + 4, 32'h7);
    push("cnt_start", 32'hFFFF); step(1); check({16'h0, LEDS});
    push("cnt_wrap",  32'h0000); step(1); check({16'h0, LEDS});
    push("cnt_one",   32'h0001); step(1); check({16'h0, LEDS});
    wr(BASE, 32'h1234);
    push("collide", 32'h1234); step(1); check({16'h0, LEDS});
    push("collide_next", 32'h1235); step(1); check({16'h0, LEDS});
    // Blink, then disable, then sticky STATUS
    wr(BASE + 4, 32'h0); wr(BASE, 32'h00FF); wr(BASE + 8, 32'h1); wr(BASE + 4, 32'h5);
    push("blink_on0",  32'h00FF); step(1); check({16'h0, LEDS});
    push("blink_off0", 32'h0000); step(2); check({16'h0, LEDS});
    push("blink_on1",  32'h00FF); step(2); check({16'h0, LEDS});
    push("blink_off1", 32'h0000); step(2); check({16'h0, LEDS});
    wr(BASE + 4, 32'h1);
    push("dis_leds0", 32'h00FF); step(1); check({16'h0, LEDS});
    push("dis_leds1", 32'h00FF); step(3); check({16'h0, LEDS});
    push("stat_pend",  32'h1); rd(BASE + 12); check(ReadData);
    push("stat_clear", 32'h0); rd(BASE + 12); check(ReadData);
    // Readback and unmapped offsets
    push("rd_period", 32'h1);  rd(BASE + 8);    check(ReadData);
    push("rd_ctrl",   32'h1);  rd(BASE + 4);    check(ReadData);
    push("rd_unmap",  32'h0);  rd(BASE + 20);   check(ReadData);
    push("rd_outwin", 32'h0);  rd(32'h200);     check(ReadData);
`ifdef LED_PWM_EN
    begin
      int on_cnt = 0;
      wr(BASE + 16, 32'd64); wr(BASE, 32'hFFFF); wr(BASE + 4, 32'h0);
      push("rd_duty", 32'd64); rd(BASE + 16); check(ReadData);
      step(1);
      for (int i = 0; i < 256; i++) begin
        if (LEDS == 16'hFFFF) on_cnt++;
        step(1);
      end
      push("pwm_on", 32'd64); check(32'(on_cnt));
    end
`else
    wr(BASE + 16, 32'hAA);
    push("rd_duty_unmapped", 32'h0); rd(BASE + 16); check(ReadData);
`endif
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
